hazard_forward_ctrl: RTL and testbench
======================================

# hazard_forward_ctrl

- Pipeline hazard controller for the 5-stage core. It produces the 2-bit operand-forwarding selects consumed by the EX-stage operand muxes.
- It keeps a shadow pipeline (EX/MEM/WB) of destination-register information, detects load-use hazards, and issues stall, flush and bubble control.
- Sits beside the ID/EX pipeline register and advances with it.

## Interface
Parameters:
- REG_ADDR_W, 5, register-number width
- PERF_W, 16, width of the saturating stall counter

Ports:
- clock  input  1  core clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- id_valid  input  1  ID stage holds a real instruction
- id_rs  input  REG_ADDR_W  source register A of ID instruction
- id_rt  input  REG_ADDR_W  source register B of ID instruction
- id_uses_rs  input  1  ID instruction reads rs
- id_uses_rt  input  1  ID instruction reads rt
- id_wr_en  input  1  ID instruction writes a register
- id_wr_reg  input  REG_ADDR_W  destination of ID instruction
- id_is_load  input  1  ID instruction is a load
- ex_branch_taken  input  1  branch resolved taken in EX this cycle
- mem_wait  input  1  data memory not ready; whole pipeline freezes
- stall_out  output  1  hold PC and IF/ID register (combinational)
- bubble_out  output  1  load ID/EX with a NOP this edge (combinational)
- flush_out  output  1  kill IF/ID contents this edge (combinational)
- fwd_sel_a  output  2  EX operand A select (registered)
- fwd_sel_b  output  2  EX operand B select (registered)
- stall_count  output  PERF_W  saturating count of load-use stall cycles

## Operation
- Shadow stages EX, MEM and WB each hold: valid, wr_en, wr_reg, is_load.
- advance = !mem_wait.
- On an advance edge:
  - WB<=MEM and MEM<=EX.
  - EX<=ID fields, but EX<=invalid when bubble_out is 1.
- Forward select encoding:
  - 0: register file
  - 1: EX/MEM ALU result
  - 2: MEM/WB result
  - 3: reserved, never driven
- Select computation is per operand, evaluated at the advance edge that moves the ID instruction into EX, using pre-edge shadow contents. Priority:
  - EX valid, wr_en, wr_reg==src, src!=0, EX not a load → 1
  - else MEM valid, wr_en, wr_reg==src, src!=0 → 2
  - else → 0
  - An operand not used (id_uses_* = 0) always gets select 0.
- WB-stage matches give select 0: the register file is write-first.
- load_use = id_valid & EX.valid & EX.is_load & EX.wr_en & EX.wr_reg!=0 & ((id_uses_rs & id_rs==EX.wr_reg) | (id_uses_rt & id_rt==EX.wr_reg)).
- stall_out = mem_wait | (load_use & !ex_branch_taken).
- bubble_out = !mem_wait & (load_use | ex_branch_taken).
- flush_out = ex_branch_taken & !mem_wait.
- When a bubble is inserted, fwd_sel_a and fwd_sel_b are loaded with 0.
- stall_count increments on each cycle where load_use & advance & !ex_branch_taken; it saturates at all-ones.

## Timing
- Reset (async assert, sync-released by the top level) forces:
  - all shadow valid = 0
  - fwd_sel_a = fwd_sel_b = 0
  - stall_count = 0
  - stall_out = bubble_out = flush_out = 0
- fwd_sel_* change only on advance edges. They are held unchanged while mem_wait = 1.
- Forwarding latency: the select is valid for the entire cycle the instruction occupies EX, i.e. one edge after its ID cycle.
- Load-use costs exactly one stall cycle. On the next advance the load is in MEM, the dependent instruction advances, and it receives select 2.
- Simultaneous events:
  - ex_branch_taken and load_use: the flush wins, with no stall. The ID instruction is killed (bubble) and stall_count does not increment.
  - mem_wait with anything: the freeze wins. There is no bubble and no flush, and the event is re-evaluated on the first cycle where mem_wait = 0.
- Reset mid-stall: all state clears immediately, and the first post-reset cycle shows no hazard.
- Register 0 never causes forwarding or a stall.

## Structure
- A shared package (core_pkg) holds:
  - the forward-select constants FWD_RF=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2
  - REG_ADDR_W
  - the shadow-stage struct typedef (valid, wr_en, wr_reg, is_load)
- One natural sub-module, fwd_select: a combinational per-operand select generator (source reg, use flag, EX and MEM shadow entries → 2-bit select). It is instantiated twice.
- The shadow pipeline, hazard logic and counter live in the top module.

## Test plan
- EX-stage dependency: prior instruction add r3, next reads rs=r3 with no load → fwd_sel_a=1 the following cycle, fwd_sel_b=0, and no stall.
- Two-back dependency: instruction writing r5, one unrelated instruction, then a reader of rt=r5 → fwd_sel_b=2. If the intervening instruction also writes r5 → fwd_sel_b=1 (EX priority).
- Load-use: load r7, then a reader of rs=r7:
  - stall_out=1 and bubble_out=1 for one cycle, stall_count=1
  - the reader then enters EX with fwd_sel_a=2
- Branch collision: load r7 in EX, ID reads r7, ex_branch_taken=1 in the same cycle → stall_out=0, flush_out=1, bubble_out=1, stall_count unchanged.
- Freeze: assert mem_wait for 3 cycles mid-dependency:
  - stall_out=1 throughout, with bubble and flush both 0
  - fwd_sel and shadow state held
  - forwarding resolves correctly after release
- Register 0 and reset: writer of r0 followed by a reader of r0 → selects 0 with no stall. Assert reset_n low mid-stall → all outputs 0 asynchronously, and stall_count=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: forwarding-select encodings, register-number width
// and the shadow-pipeline entry used by the hazard controller.
package core_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [REG_ADDR_W-1:0] wr_reg;
        logic                  is_load;
    } shadow_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding select: picks the youngest in-flight producer of src,
// skipping loads in EX (their data is not ready until MEM/WB).
module fwd_select
    import core_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  uses,
    input  shadow_t               ex,
    input  shadow_t               mem,
    output logic [1:0]            sel
);

    logic src_nz;
    logic ex_hit;
    logic mem_hit;

    always_comb begin
        src_nz  = (src != '0);
        ex_hit  = ex.valid & ex.wr_en & ~ex.is_load & (ex.wr_reg == src);
        mem_hit = mem.valid & mem.wr_en & (mem.wr_reg == src);
        sel     = FWD_RF;
        if (uses && src_nz) begin
            if (ex_hit) begin
                sel = FWD_EXMEM;
            end else if (mem_hit) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard controller: shadow EX/MEM/WB destination tracking, load-use stall,
// branch flush/bubble control and registered operand-forwarding selects.
module hazard_forward_ctrl #(
    parameter int unsigned REG_ADDR_W = core_pkg::REG_ADDR_W,
    parameter int unsigned PERF_W     = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_wr_en,
    input  logic [REG_ADDR_W-1:0] id_wr_reg,
    input  logic                  id_is_load,
    input  logic                  ex_branch_taken,
    input  logic                  mem_wait,
    output logic                  stall_out,
    output logic                  bubble_out,
    output logic                  flush_out,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic [PERF_W-1:0]     stall_count
);

    import core_pkg::shadow_t;
    import core_pkg::FWD_RF;

    shadow_t ex_q, mem_q, wb_q, ex_d;
    logic [1:0] fwd_a_q, fwd_b_q;
    logic [1:0] sel_a, sel_b;
    logic [PERF_W-1:0] stall_count_q;
    logic advance;
    logic load_use;
    logic count_en;

    // WB is tracked for completeness; the register file is write-first so it never forwards.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    fwd_select u_fwd_a (
        .src  (id_rs),
        .uses (id_valid & id_uses_rs),
        .ex   (ex_q),
        .mem  (mem_q),
        .sel  (sel_a)
    );

    fwd_select u_fwd_b (
        .src  (id_rt),
        .uses (id_valid & id_uses_rt),
        .ex   (ex_q),
        .mem  (mem_q),
        .sel  (sel_b)
    );

    always_comb begin
        advance  = ~mem_wait;
        load_use = id_valid & ex_q.valid & ex_q.is_load & ex_q.wr_en & (ex_q.wr_reg != '0) &
                   ((id_uses_rs & (id_rs == ex_q.wr_reg)) |
                    (id_uses_rt & (id_rt == ex_q.wr_reg)));
        // Outputs are gated by reset so they read 0 while reset is held, whatever the inputs.
        stall_out  = reset_n & (mem_wait | (load_use & ~ex_branch_taken));
        bubble_out = reset_n & advance & (load_use | ex_branch_taken);
        flush_out  = reset_n & advance & ex_branch_taken;
        count_en   = load_use & advance & ~ex_branch_taken & (stall_count_q != '1);

        ex_d         = '0;
        ex_d.valid   = id_valid;
        ex_d.wr_en   = id_wr_en;
        ex_d.wr_reg  = id_wr_reg;
        ex_d.is_load = id_is_load;
        if (bubble_out) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else if (advance) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_d;
            if (bubble_out) begin
                fwd_a_q <= FWD_RF;
                fwd_b_q <= FWD_RF;
            end else begin
                fwd_a_q <= sel_a;
                fwd_b_q <= sel_b;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_q <= '0;
        end else if (count_en) begin
            stall_count_q <= stall_count_q + 1'b1;
        end
    end

    assign fwd_sel_a   = fwd_a_q;
    assign fwd_sel_b   = fwd_b_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed self-checking bench for hazard_forward_ctrl.
module tb_hazard_forward_ctrl;

    logic        clock;
    logic        reset_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_wr_en;
    logic [4:0]  id_wr_reg;
    logic        id_is_load;
    logic        ex_branch_taken;
    logic        mem_wait;
    logic        stall_out;
    logic        bubble_out;
    logic        flush_out;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    hazard_forward_ctrl dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_wr_en        (id_wr_en),
        .id_wr_reg       (id_wr_reg),
        .id_is_load      (id_is_load),
        .ex_branch_taken (ex_branch_taken),
        .mem_wait        (mem_wait),
        .stall_out       (stall_out),
        .bubble_out      (bubble_out),
        .flush_out       (flush_out),
        .fwd_sel_a       (fwd_sel_a),
        .fwd_sel_b       (fwd_sel_b),
        .stall_count     (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past one rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic wen,
                          input logic [4:0] wreg, input logic ld);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_uses_rs = urs;
        id_uses_rt = urt;
        id_wr_en   = wen;
        id_wr_reg  = wreg;
        id_is_load = ld;
    endtask

    task automatic drain();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        ex_branch_taken = 1'b0;
        mem_wait        = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mem_wait = 1'b1;
        #1;
        checks++;
        if (stall_out !== 1'b0 || bubble_out !== 1'b0 || flush_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: stall=%b bubble=%b flush=%b want 000",
                     stall_out, bubble_out, flush_out);
        end
        mem_wait = 1'b0;
        step();
        checks++;
        if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin
            errors++;
            $display("FAIL reset_fwd: a=%0d b=%0d want 0 0", fwd_sel_a, fwd_sel_b);
        end
        checks++;
        if (stall_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", stall_count);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_ex_forward();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0); // add r3,r1,r2
        step();
        set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0); // reads r3,r4
        #1;
        checks++;
        if (stall_out !== 1'b0 || bubble_out !== 1'b0) begin
            errors++;
            $display("FAIL ex_fwd_nostall: stall=%b bubble=%b want 00", stall_out, bubble_out);
        end
        step();
        checks++;
        if (fwd_sel_a !== 2'd1 || fwd_sel_b !== 2'd0) begin
            errors++;
            $display("FAIL ex_fwd_sel: a=%0d b=%0d want 1 0", fwd_sel_a, fwd_sel_b);
        end
        drain();
    endtask

    task automatic test_two_back();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0); // writes r5
        step();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0); // unrelated
        step();
        set_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0); // reads rt=r5
        step();
        checks++;
        if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd2) begin
            errors++;
            $display("FAIL two_back_mem: a=%0d b=%0d want 0 2", fwd_sel_a, fwd_sel_b);
        end
        drain();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
        step();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0); // also writes r5
        step();
        set_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
        step();
        checks++;
        if (fwd_sel_b !== 2'd1) begin
            errors++;
            $display("FAIL two_back_prio: b=%0d want 1", fwd_sel_b);
        end
        drain();
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1); // lw r7
        step();
        set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0); // reads r7
        #1;
        checks++;
        if (stall_out !== 1'b1 || bubble_out !== 1'b1 || flush_out !== 1'b0) begin
            errors++;
            $display("FAIL lu_ctrl: stall=%b bubble=%b flush=%b want 110",
                     stall_out, bubble_out, flush_out);
        end
        step();
        checks++;
        if (stall_count !== 16'd1 || fwd_sel_a !== 2'd0) begin
            errors++;
            $display("FAIL lu_bubble: count=%0d a=%0d want 1 0", stall_count, fwd_sel_a);
        end
        checks++;
        if (stall_out !== 1'b0 || bubble_out !== 1'b0) begin
            errors++;
            $display("FAIL lu_one_cycle: stall=%b bubble=%b want 00", stall_out, bubble_out);
        end
        step();
        checks++;
        if (fwd_sel_a !== 2'd2 || fwd_sel_b !== 2'd0 || stall_count !== 16'd1) begin
            errors++;
            $display("FAIL lu_fwd: a=%0d b=%0d count=%0d want 2 0 1",
                     fwd_sel_a, fwd_sel_b, stall_count);
        end
        drain();
    endtask

    task automatic test_branch_collision();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1);
        step();
        set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0);
        ex_branch_taken = 1'b1;
        #1;
        checks++;
        if (stall_out !== 1'b0 || flush_out !== 1'b1 || bubble_out !== 1'b1) begin
            errors++;
            $display("FAIL br_ctrl: stall=%b flush=%b bubble=%b want 011",
                     stall_out, flush_out, bubble_out);
        end
        step();
        ex_branch_taken = 1'b0;
        checks++;
        if (stall_count !== 16'd1 || fwd_sel_a !== 2'd0) begin
            errors++;
            $display("FAIL br_count: count=%0d a=%0d want 1 0", stall_count, fwd_sel_a);
        end
        drain();
    endtask

    task automatic test_freeze();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0); // writes r3
        step();
        set_id(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0); // reads r3, no write
        step();
        set_id(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0); // reads r3 again
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_branch_taken = (i == 1);
            #1;
            checks++;
            if (stall_out !== 1'b1 || bubble_out !== 1'b0 || flush_out !== 1'b0) begin
                errors++;
                $display("FAIL frz_ctrl[%0d]: stall=%b bubble=%b flush=%b want 100",
                         i, stall_out, bubble_out, flush_out);
            end
            step();
            checks++;
            if (fwd_sel_a !== 2'd1) begin
                errors++;
                $display("FAIL frz_hold[%0d]: a=%0d want 1", i, fwd_sel_a);
            end
        end
        ex_branch_taken = 1'b0;
        mem_wait        = 1'b0;
        step();
        checks++;
        if (fwd_sel_a !== 2'd2 || stall_count !== 16'd1) begin
            errors++;
            $display("FAIL frz_release: a=%0d count=%0d want 2 1", fwd_sel_a, stall_count);
        end
        drain();
    endtask

    task automatic test_reg_zero();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1); // lw r0
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0); // add r0,r0,r0
        #1;
        checks++;
        if (stall_out !== 1'b0 || bubble_out !== 1'b0) begin
            errors++;
            $display("FAIL r0_nostall: stall=%b bubble=%b want 00", stall_out, bubble_out);
        end
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0); // reads r0
        step();
        checks++;
        if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0 || stall_count !== 16'd1) begin
            errors++;
            $display("FAIL r0_fwd: a=%0d b=%0d count=%0d want 0 0 1",
                     fwd_sel_a, fwd_sel_b, stall_count);
        end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1);
        step();
        set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0);
        #1;
        checks++;
        if (stall_out !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: stall=%b want 1", stall_out);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (stall_out !== 1'b0 || bubble_out !== 1'b0 || flush_out !== 1'b0 ||
            fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_async: st=%b bu=%b fl=%b a=%0d b=%0d cnt=%0d want all 0",
                     stall_out, bubble_out, flush_out, fwd_sel_a, fwd_sel_b, stall_count);
        end
        step();
        reset_n = 1'b1;
        #1;
        checks++;
        if (stall_out !== 1'b0 || bubble_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: stall=%b bubble=%b want 00", stall_out, bubble_out);
        end
        drain();
    endtask

    initial begin
        reset_n         = 1'b0;
        ex_branch_taken = 1'b0;
        mem_wait        = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        test_reset();
        test_ex_forward();
        test_two_back();
        test_load_use();
        test_branch_collision();
        test_freeze();
        test_reg_zero();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
